// File: rtl/frame_buffer.sv
// Double-buffered LED channel store: gamma/brightness write pipeline into the
// back bank, registered driver reads from the front bank, tear-free swapping.
module frame_buffer #(
    parameter int c_ledboards = 30,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_bpc       = 12
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [c_addr_w-1:0] i_wr_addr,
    input  logic [7:0]          i_wr_data,
    input  logic [7:0]          i_brightness,
    input  logic                i_swap_req,
    output logic                o_wr_ready,
    output logic                o_swap_pending,
    input  logic [c_addr_w-1:0] i_rd_addr,
    output logic [c_bpc-1:0]    o_rd_data
);

    localparam logic [c_addr_w:0]   chan_count = (c_addr_w + 1)'(c_channels);
    localparam logic [c_addr_w-1:0] last_addr  = c_addr_w'(c_channels - 1);

    typedef enum logic {
        st_idle,
        st_pending
    } swap_state_t;

    swap_state_t state;
    swap_state_t state_nx;

    logic                bank;
    logic [c_addr_w-1:0] rd_addr_q;

    logic                s1_valid;
    logic                s1_bank;
    logic [c_addr_w-1:0] s1_addr;
    logic [7:0]          s1_bright;
    logic [c_bpc-1:0]    s1_gamma;

    logic [c_bpc-1:0] mem [0:1][0:c_channels-1];

    logic                wr_accept;
    logic [15:0]         square;
    logic [c_bpc-1:0]    gamma;
    logic [8:0]          bright_p1;
    logic [c_bpc+8:0]    scaled_full;
    logic [c_bpc-1:0]    scaled;
    logic                boundary;
    logic                swap_now;
    logic                rd_bank;
    logic                rd_in_range;

    assign o_swap_pending = (state == st_pending);
    assign o_wr_ready     = ~o_swap_pending;

    assign wr_accept = i_wr_en & o_wr_ready
                     & ({1'b0, i_wr_addr} < chan_count);

    // Square-law gamma keeps the top c_bpc bits of the 16-bit square
    assign square = 16'(i_wr_data) * 16'(i_wr_data);
    assign gamma  = c_bpc'(square >> (16 - c_bpc));

    assign bright_p1   = {1'b0, s1_bright} + 9'd1;
    assign scaled_full = (c_bpc + 9)'(s1_gamma) * (c_bpc + 9)'(bright_p1);
    assign scaled      = c_bpc'(scaled_full >> 8);

    // Swap only on the driver's wrap to address 0 with nothing in flight
    assign boundary = (rd_addr_q == last_addr) && (i_rd_addr == '0);
    assign swap_now = o_swap_pending & boundary & ~s1_valid;

    assign rd_bank     = bank ^ swap_now;
    assign rd_in_range = ({1'b0, i_rd_addr} < chan_count);

    always_comb begin
        state_nx = state;
        unique case (state)
            st_idle:    if (i_swap_req) state_nx = st_pending;
            st_pending: if (swap_now)   state_nx = st_idle;
            default:    state_nx = st_idle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= st_idle;
            bank  <= 1'b0;
        end else begin
            state <= state_nx;
            if (swap_now) bank <= ~bank;
        end
    end

    always_ff @(posedge i_clk) begin
        rd_addr_q <= i_rd_addr;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= wr_accept;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            s1_addr   <= i_wr_addr;
            s1_bank   <= ~bank;
            s1_bright <= i_brightness;
            s1_gamma  <= gamma;
        end
    end

    always_ff @(posedge i_clk) begin
        if (s1_valid && !i_rst) begin
            mem[s1_bank][s1_addr] <= scaled;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data <= '0;
        end else if (rd_in_range) begin
            o_rd_data <= mem[rd_bank][i_rd_addr];
        end else begin
            o_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: frame-level reference model checked every cycle,
// plus hand-computed readbacks of gamma/brightness and swap timing.
module tb_frame_buffer;

    localparam int C   = 960;
    localparam int AW  = 10;
    localparam int BPC = 12;

    logic           clk;
    logic           rst;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     wr_data;
    logic [7:0]     bright;
    logic           swap_req;
    logic           wr_ready;
    logic           swap_pending;
    logic [AW-1:0]  rd_addr;
    logic [BPC-1:0] rd_data;

    frame_buffer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_brightness   (bright),
        .i_swap_req     (swap_req),
        .o_wr_ready     (wr_ready),
        .o_swap_pending (swap_pending),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int level(input int d, input int b);
        int g;
        g = (d * d) >> (16 - BPC);
        return (g * (b + 1)) >> 8;
    endfunction

    // Reference model: two banks of channel words plus a list of
    // writes that have been accepted but not yet stored
    typedef struct {
        int bk;
        int a;
        int v;
    } wr_t;

    int  mem   [2][C];
    bit  known [2][C];
    wr_t inflight[$];
    int  m_bank = 0;
    bit  m_pend = 1'b0;
    int  m_prev = 0;
    int  m_rd = 0;
    bit  m_rd_known = 1'b0;
    bit  m_live = 1'b0;

    always @(posedge clk) begin
        int ra;
        int rb;
        bit wrap;
        bit sw;
        ra = int'(rd_addr);
        if (rst) begin
            m_bank = 0;
            m_pend = 1'b0;
            inflight.delete();
            m_rd = 0;
            m_rd_known = 1'b1;
            m_live = 1'b1;
        end else begin
            wrap = (m_prev == C - 1) && (ra == 0);
            sw = m_pend && wrap && (inflight.size() == 0);
            rb = sw ? 1 - m_bank : m_bank;
            if (ra < C) begin
                m_rd = mem[rb][ra];
                m_rd_known = known[rb][ra];
            end else begin
                m_rd = 0;
                m_rd_known = 1'b1;
            end
            foreach (inflight[i]) begin
                mem[inflight[i].bk][inflight[i].a] = inflight[i].v;
                known[inflight[i].bk][inflight[i].a] = 1'b1;
            end
            inflight.delete();
            if (wr_en && !m_pend && int'(wr_addr) < C)
                inflight.push_back('{1 - m_bank, int'(wr_addr),
                                     level(int'(wr_data), int'(bright))});
            if (sw) begin
                m_bank = 1 - m_bank;
                m_pend = 1'b0;
            end else if (swap_req) begin
                m_pend = 1'b1;
            end
        end
        m_prev = ra;
    end

    always @(posedge clk) begin
        #2;
        if (m_live) begin
            chk("pending", 32'(swap_pending), 32'(m_pend));
            chk("ready", 32'(wr_ready), 32'(!m_pend));
            if (m_rd_known)
                chk("rd_data", 32'(rd_data), 32'(m_rd));
        end
    end

    logic [BPC-1:0] cap  [C];
    logic           pcap [C];

    task automatic wr(input int a, input int d, input int b, input bit req);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = 8'(d);
        bright   = 8'(b);
        swap_req = req;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic req_pulse();
        @(negedge clk);
        swap_req = 1'b1;
        @(posedge clk);
        #1;
        swap_req = 1'b0;
    endtask

    task automatic sweep(input int req_at, input int wr_at, input int wa,
                         input int wd, input int wb);
        for (int a = 0; a < C; a++) begin
            @(negedge clk);
            rd_addr = AW'(a);
            if (a == req_at) swap_req = 1'b1;
            if (a == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = AW'(wa);
                wr_data = 8'(wd);
                bright  = 8'(wb);
            end
            @(posedge clk);
            #2;
            cap[a]   = rd_data;
            pcap[a]  = swap_pending;
            wr_en    = 1'b0;
            swap_req = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        bright = '0;
        swap_req = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pending", 32'(swap_pending), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill bank 1, then the gamma/brightness vectors
        for (int a = 0; a < C; a++) wr(a, a % 256, 255, 1'b0);
        wr(5, 255, 255, 1'b0);
        wr(6, 255, 127, 1'b0);
        wr(7, 16, 255, 1'b0);
        wr(8, 0, 99, 1'b0);
        wr(9, 255, 0, 1'b0);
        wr(960, 255, 255, 1'b0);
        wr(1023, 1, 1, 1'b0);
        req_pulse();
        #1;
        chk("req_pending", 32'(swap_pending), 32'd1);
        chk("req_ready", 32'(wr_ready), 32'd0);
        wr(5, 0, 0, 1'b0);
        sweep(-1, -1, 0, 0, 0);
        sweep(-1, -1, 0, 0, 0);
        chk("d255_b255", 32'(cap[5]), 32'd4064);
        chk("d255_b127", 32'(cap[6]), 32'd2032);
        chk("d16_b255", 32'(cap[7]), 32'd16);
        chk("d0_b99", 32'(cap[8]), 32'd0);
        chk("d255_b0", 32'(cap[9]), 32'd15);
        chk("swapped_pending", 32'(pcap[0]), 32'd0);

        // Fill bank 0; request swap mid-frame
        for (int a = 0; a < C; a++) wr(a, 255 - (a % 256), 200, 1'b0);
        sweep(100, -1, 0, 0, 0);
        chk("mid_before_req", 32'(pcap[99]), 32'd0);
        chk("mid_after_req", 32'(pcap[100]), 32'd1);
        chk("mid_held_to_end", 32'(pcap[C-1]), 32'd1);
        sweep(-1, -1, 0, 0, 0);
        chk("newbank_addr0", 32'(cap[0]), 32'd3190);
        chk("newbank_addr1", 32'(cap[1]), 32'd3165);
        chk("newbank_pending", 32'(pcap[0]), 32'd0);

        // Write in flight at the boundary defers the swap one frame
        sweep(C - 1, C - 1, 20, 255, 255);
        sweep(-1, -1, 0, 0, 0);
        chk("deferred_addr0", 32'(cap[0]), 32'd3190);
        chk("deferred_pending", 32'(pcap[0]), 32'd1);
        sweep(-1, -1, 0, 0, 0);
        chk("late_swap_addr20", 32'(cap[20]), 32'd4064);
        chk("late_swap_addr0", 32'(cap[0]), 32'd0);
        chk("late_swap_pending", 32'(pcap[0]), 32'd0);

        // Reset with a write in flight and a swap pending
        wr(0, 100, 255, 1'b1);
        chk("pre_rst_pending", 32'(swap_pending), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rd_addr = '0;
        @(posedge clk);
        #2;
        chk("mid_rst_pending", 32'(swap_pending), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready), 32'd1);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Dropped writes and a stalled driver
        wr(960, 255, 255, 1'b0);
        wr(1023, 255, 255, 1'b0);
        req_pulse();
        wr(5, 0, 0, 1'b0);
        repeat (10) @(negedge clk);
        chk("stall_pending", 32'(swap_pending), 32'd1);
        chk("stall_ready", 32'(wr_ready), 32'd0);
        sweep(-1, -1, 0, 0, 0);
        chk("post_rst_bank0", 32'(cap[0]), 32'd3190);
        sweep(-1, -1, 0, 0, 0);
        chk("dropped_addr5", 32'(cap[5]), 32'd4064);
        chk("final_addr0", 32'(cap[0]), 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
